// File: rtl/threshold_input_v5.sv
// Debounced up/down/select buttons driving NUM_CH saturating threshold registers with auto-repeat.
// Latency: raw press to new threshold in DEBOUNCE_CYCLES+3 clocks; no flow control, every press event is taken.
module threshold_input_v5 #(
  parameter int WIDTH           = 8,
  parameter int NUM_CH          = 2,
  parameter int STEP            = 2,
  parameter int MIN             = 2,
  parameter int MAX             = 254,
  parameter int INIT            = 12,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int SELW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    button_up,
  input  logic                    button_down,
  input  logic                    button_sel,
  output logic [NUM_CH*WIDTH-1:0] threshold_flat,
  output logic [WIDTH-1:0]        threshold,
  output logic [SELW-1:0]         ch_sel,
  output logic                    changed
);

  localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HCW  = $clog2(HMAX + 1);

  localparam logic [DCW-1:0]   DB_LAST     = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0]   DELAY_LAST  = HCW'(REPEAT_DELAY - 1);
  localparam logic [HCW-1:0]   PERIOD_LAST = HCW'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH:0]   STEP_W      = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   MIN_W       = (WIDTH + 1)'(MIN);
  localparam logic [WIDTH:0]   MAX_W       = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH-1:0] STEP_V      = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MIN_V       = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V      = WIDTH'(INIT);
  localparam logic [SELW-1:0]  SEL_LAST    = SELW'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Bit order in the button vectors: 0 = up, 1 = down, 2 = select.
  logic [2:0]     raw, sync1, sync2, db, db_q, armed, press;
  logic [DCW-1:0] dcnt [3];

  assign raw = {button_sel, button_down, button_up};

  // Synchronisers come out of reset at 1 and a button is only armed once it has been
  // seen released, so a button held across reset never yields a press event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '0;
      db_q  <= '0;
      armed <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      armed <= armed | (~sync2 & ~db);
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          db[i]   <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DCW'(1);
        end
      end
    end
  end

  assign press = db & ~db_q & armed;

  state_t         state, state_nx;
  logic           dir_up, dir_up_nx;
  logic [HCW-1:0] hold, hold_nx;
  logic           step, step_up;
  logic           both, dir_held;

  assign both     = db[0] & db[1];
  assign dir_held = dir_up ? db[0] : db[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      dir_up <= 1'b0;
      hold   <= '0;
    end else begin
      state  <= state_nx;
      dir_up <= dir_up_nx;
      hold   <= hold_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    dir_up_nx = dir_up;
    hold_nx   = hold;
    step      = 1'b0;
    step_up   = dir_up;
    case (state)
      IDLE: begin
        if ((press[0] | press[1]) && (db[0] ^ db[1])) begin
          step      = 1'b1;
          step_up   = db[0];
          dir_up_nx = db[0];
          hold_nx   = '0;
          state_nx  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        // Release wins over a step falling due in the same cycle.
        if (both || !dir_held) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (hold == ((state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          step     = 1'b1;
          hold_nx  = '0;
          state_nx = REPEAT;
        end else begin
          hold_nx = hold + HCW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [NUM_CH-1:0][WIDTH-1:0] chan;
  logic [WIDTH-1:0]             cur, nxt;
  logic [WIDTH:0]               sum;

  always_comb begin
    cur = chan[ch_sel];
    sum = {1'b0, cur} + STEP_W;
    nxt = cur;
    if (step_up) nxt = (sum > MAX_W) ? MAX_V : sum[WIDTH-1:0];
    else         nxt = ({1'b0, cur} < (MIN_W + STEP_W)) ? MIN_V : (cur - STEP_V);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chan    <= {NUM_CH{INIT_V}};
      ch_sel  <= '0;
      changed <= 1'b0;
    end else begin
      changed <= step && (nxt != cur);
      if (step) chan[ch_sel] <= nxt;
      if (press[2]) ch_sel <= (ch_sel == SEL_LAST) ? '0 : ch_sel + SELW'(1);
    end
  end

  assign threshold_flat = chan;
  assign threshold      = cur;

endmodule

// File: tb/tb_threshold_input_v5.sv
// Scoreboard bench for threshold_input_v5: two instances (INIT 12 and INIT 13) with short debounce/repeat timing.
module tb_threshold_input_v5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic up = 1'b0, dn = 1'b0, sel = 1'b0;
  logic up2 = 1'b0, dn2 = 1'b0, sel2 = 1'b0;

  logic [15:0] flat_m, flat_o;
  logic [7:0]  thr_m, thr_o;
  logic        chs_m, chs_o, chg_m, chg_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          c;
    logic [15:0] flat;
    logic        s;
  } exp_t;

  exp_t       q_m[$];
  exp_t       q_o[$];
  logic [7:0] mdl_m [2];
  logic [7:0] mdl_o [2];
  logic       msel_m, msel_o;

  threshold_input_v5 #(
    .WIDTH(8), .NUM_CH(2), .STEP(2), .MIN(2), .MAX(254), .INIT(12),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) u_main (
    .clk(clk), .resetn(resetn), .button_up(up), .button_down(dn), .button_sel(sel),
    .threshold_flat(flat_m), .threshold(thr_m), .ch_sel(chs_m), .changed(chg_m)
  );

  threshold_input_v5 #(
    .WIDTH(8), .NUM_CH(2), .STEP(2), .MIN(2), .MAX(254), .INIT(13),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) u_odd (
    .clk(clk), .resetn(resetn), .button_up(up2), .button_down(dn2), .button_sel(sel2),
    .threshold_flat(flat_o), .threshold(thr_o), .ch_sel(chs_o), .changed(chg_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] v, input bit up_dir);
    int r;
    r = int'(v);
    if (up_dir) r = (r + 2 > 254) ? 254 : r + 2;
    else        r = (r < 2 + 2) ? 2 : r - 2;
    return 8'(r);
  endfunction

  task automatic reset_models();
    mdl_m[0] = 8'd12; mdl_m[1] = 8'd12; msel_m = 1'b0;
    mdl_o[0] = 8'd13; mdl_o[1] = 8'd13; msel_o = 1'b0;
  endtask

  // Queue the expected changed pulses for a hold starting at cycle t0:
  // first step at t0+7, first repeat 20 later, then every 5.
  task automatic plan(input bit odd, input int t0, input int nsteps, input bit up_dir);
    exp_t       e;
    logic [7:0] nv;
    int         ec;
    for (int k = 1; k <= nsteps; k++) begin
      ec = (k == 1) ? t0 + 7 : t0 + 27 + 5 * (k - 2);
      if (!odd) begin
        nv = model_step(mdl_m[msel_m], up_dir);
        if (nv != mdl_m[msel_m]) begin
          mdl_m[msel_m] = nv;
          e.c = ec; e.flat = {mdl_m[1], mdl_m[0]}; e.s = msel_m;
          q_m.push_back(e);
        end
      end else begin
        nv = model_step(mdl_o[msel_o], up_dir);
        if (nv != mdl_o[msel_o]) begin
          mdl_o[msel_o] = nv;
          e.c = ec; e.flat = {mdl_o[1], mdl_o[0]}; e.s = msel_o;
          q_o.push_back(e);
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (chg_m === 1'b1) begin
        checks++;
        if (q_m.size() == 0) begin
          errors++;
          $display("FAIL main_unexpected_changed: cycle %0d flat %h, no step expected", cyc, flat_m);
        end else begin
          e = q_m.pop_front();
          if (cyc != e.c || flat_m !== e.flat || chs_m !== e.s) begin
            errors++;
            $display("FAIL main_step: cycle %0d flat %h sel %0d, expected cycle %0d flat %h sel %0d",
                     cyc, flat_m, chs_m, e.c, e.flat, e.s);
          end
        end
      end
      if (chg_o === 1'b1) begin
        checks++;
        if (q_o.size() == 0) begin
          errors++;
          $display("FAIL odd_unexpected_changed: cycle %0d flat %h, no step expected", cyc, flat_o);
        end else begin
          e = q_o.pop_front();
          if (cyc != e.c || flat_o !== e.flat || chs_o !== e.s) begin
            errors++;
            $display("FAIL odd_step: cycle %0d flat %h sel %0d, expected cycle %0d flat %h sel %0d",
                     cyc, flat_o, chs_o, e.c, e.flat, e.s);
          end
        end
      end
    end
  endtask

  task automatic press_up_main(input int hold);
    int t0;
    t0 = cyc;
    plan(1'b0, t0, 1, 1'b1);
    up = 1'b1; tick(hold); up = 1'b0; tick(20);
  endtask

  initial begin
    int t0;
    fork
      monitor();
    join_none
    reset_models();

    // Reset and idle
    tick(3);
    resetn = 1'b1;
    check("reset_flat", flat_m, 16'h0C0C);
    check("reset_sel", 16'(chs_m), 16'd0);
    check("reset_changed", 16'(chg_m), 16'd0);
    check("reset_threshold", 16'(thr_m), 16'd12);
    check("reset_flat_odd", flat_o, 16'h0D0D);
    tick(50);
    check("idle_flat", flat_m, 16'h0C0C);

    // Glitchy up: 3-cycle pulses are rejected, a 10-cycle press steps once
    for (int g = 0; g < 3; g++) begin
      up = 1'b1; tick(3); up = 1'b0; tick(6);
    end
    tick(10);
    check("glitch_flat", flat_m, 16'h0C0C);
    press_up_main(10);
    check("single_step_flat", flat_m, 16'h0C0E);

    // Auto-repeat up then down, from a fresh reset
    resetn = 1'b0; reset_models(); tick(2); resetn = 1'b1; tick(5);
    t0 = cyc;
    plan(1'b0, t0, 9, 1'b1);
    up = 1'b1; tick(60);
    check("hold_up_at_release", flat_m, 16'h0C1C);
    up = 1'b0; tick(20);
    check("hold_up_final", flat_m, 16'h0C1E);
    t0 = cyc;
    plan(1'b0, t0, 9, 1'b0);
    dn = 1'b1; tick(60); dn = 1'b0; tick(20);
    check("hold_down_final", flat_m, 16'h0C0C);

    // Channel select
    sel = 1'b1; tick(8); sel = 1'b0; msel_m = 1'b1; tick(10);
    check("sel_ch1", 16'(chs_m), 16'd1);
    check("sel_ch1_threshold", 16'(thr_m), 16'd12);
    press_up_main(10);
    check("ch1_step_flat", flat_m, 16'h0E0C);
    check("ch1_threshold", 16'(thr_m), 16'd14);
    sel = 1'b1; tick(8); sel = 1'b0; msel_m = 1'b0; tick(10);
    check("sel_wrap", 16'(chs_m), 16'd0);
    check("sel_wrap_threshold", 16'(thr_m), 16'd12);

    // Both buttons together never step
    up = 1'b1; dn = 1'b1; tick(40); up = 1'b0; dn = 1'b0; tick(20);
    check("both_held_flat", flat_m, 16'h0E0C);

    // Reset during a repeat-state hold; held button must be released and pressed again
    t0 = cyc;
    plan(1'b0, t0, 3, 1'b1);
    up = 1'b1; tick(34);
    resetn = 1'b0; reset_models(); tick(2);
    check("midhold_reset_flat", flat_m, 16'h0C0C);
    check("midhold_reset_sel", 16'(chs_m), 16'd0);
    check("midhold_reset_changed", 16'(chg_m), 16'd0);
    resetn = 1'b1; tick(40);
    check("held_through_reset", flat_m, 16'h0C0C);
    up = 1'b0; tick(20);
    press_up_main(10);
    check("repress_after_reset", flat_m, 16'h0C0E);

    // Saturation on the INIT=13 instance: ch0 down to MIN, ch1 up to MAX
    t0 = cyc;
    plan(1'b1, t0, 9, 1'b0);
    dn2 = 1'b1; tick(60); dn2 = 1'b0; tick(20);
    check("odd_down_clamp", flat_o, 16'h0D02);
    sel2 = 1'b1; tick(8); sel2 = 1'b0; msel_o = 1'b1; tick(10);
    check("odd_sel", 16'(chs_o), 16'd1);
    check("odd_sel_threshold", 16'(thr_o), 16'd13);
    t0 = cyc;
    plan(1'b1, t0, 127, 1'b1);
    up2 = 1'b1; tick(650); up2 = 1'b0; tick(20);
    check("odd_up_clamp", flat_o, 16'hFE02);
    check("odd_up_threshold", 16'(thr_o), 16'd254);

    tick(10);
    check("main_queue_drained", 16'(q_m.size()), 16'd0);
    check("odd_queue_drained", 16'(q_o.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/threshold_input_v5.md
# threshold_input_v5

Parametrised successor to the camera-path threshold button block. It turns raw push-button inputs into one or more saturating threshold registers, with the following behaviour:
- synchroniser and debounce on every button;
- single-step on press;
- auto-repeat while a button is held;
- a select button that cycles which channel the up/down buttons adjust.

All channel thresholds are presented as a flat vector for the downstream comparator stages.

## Interface
Parameters:
- WIDTH, 8: threshold width in bits.
- NUM_CH, 2: number of independent thresholds (≥1).
- STEP, 2: increment/decrement amount (≥1).
- MIN, 2: lowest allowed value.
- MAX, 254: highest allowed value. Requires MIN ≤ INIT ≤ MAX ≤ 2^WIDTH−1.
- INIT, 12: reset value of every channel.
- DEBOUNCE_CYCLES, 50000: stable cycles required to accept a level change (≥1).
- REPEAT_DELAY, 25000000: held cycles after the first step before auto-repeat starts (≥1).
- REPEAT_PERIOD, 5000000: cycles between auto-repeat steps (≥1).

Ports:
- clk, in, 1: single clock.
- resetn, in, 1: asynchronous, active-low reset.
- button_up, in, 1: raw asynchronous button.
- button_down, in, 1: raw asynchronous button.
- button_sel, in, 1: raw asynchronous button.
- threshold_flat, out, NUM_CH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- threshold, out, WIDTH: value of the currently selected channel.
- ch_sel, out, clog2(NUM_CH) (min 1): selected channel index.
- changed, out, 1: one-cycle pulse when a channel value actually changes.

## Operation
- Reset (async assert, sync release): every channel = INIT, ch_sel = 0, changed = 0, debounced states = 0, FSM = IDLE, all counters = 0.
- Synchroniser: each raw button passes through 2 flops.
- Debounce, per button:
  - A counter runs while the synchronised level differs from the debounced state, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state takes the new level and the counter clears.
- Rising edge of debounced up/down/sel produces a one-cycle press event.
- Repeat FSM (shared by up/down), dir ∈ {UP, DOWN}:
  - IDLE: on a press event with exactly one of up/down debounced high, emit one step in that direction, load the hold counter, go to DELAY.
  - DELAY: after REPEAT_DELAY cycles, emit a step and go to REPEAT. Release of the dir button, or both buttons high, returns to IDLE with no step.
  - REPEAT: emit a step every REPEAT_PERIOD cycles. Same exit conditions as DELAY.
  - Both debounced high in any state: no step, go to or stay in IDLE. Releasing one button does not start a new sequence; a new press edge is required.
- Step arithmetic on the selected channel only, computed in WIDTH+1 bits:
  - UP: value + STEP > MAX → MAX, else value + STEP.
  - DOWN: value < MIN + STEP → MIN, else value − STEP.
  - This differs from the previous generation: near the limit the value clamps to MIN/MAX rather than refusing the step.
- changed = 1 for the cycle after a step whose result differs from the old value. A step that leaves the value unchanged because it is already at the limit produces no pulse.
- Select:
  - A sel press event sets ch_sel = (ch_sel + 1) mod NUM_CH. There is no auto-repeat on select.
  - With NUM_CH = 1, ch_sel stays 0.
- Step and sel press in the same cycle: the step applies to the old channel, and ch_sel advances in the same edge.
- FSM and hold counter do not reset on a select change. Continued holding adjusts the newly selected channel.

## Timing
- Raw level to debounced level: 2 + DEBOUNCE_CYCLES clocks.
- Debounced rise to register update: 1 clock. Total raw-press to new threshold: DEBOUNCE_CYCLES + 3 clocks.
- changed asserts in the same cycle the new register value is visible on the outputs.
- First auto-repeat step: REPEAT_DELAY clocks after the first step. Subsequent steps every REPEAT_PERIOD clocks.
- threshold and threshold_flat are registered, with no combinational path from inputs.
- resetn asserted mid-hold or mid-debounce: the block returns immediately to the reset state. A button still held at release must re-debounce and produce a fresh edge before any step.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, WIDTH=8, STEP=2, MIN=2, MAX=254, INIT=12, NUM_CH=2.

1. Reset then idle 50 cycles → threshold_flat = 0x0C0C, ch_sel = 0, changed never high.
2. Glitchy up:
   - Up pulses of 3 cycles → no change.
   - Up held 10 cycles → ch0 = 14 exactly 7 cycles after assertion, one changed pulse.
3. Up held 60 cycles → steps at +7, +27, +32, +37, … ; ch0 = 12 + 2×(1+7) = 28 at release. Down held the same way → back to 12.
4. Saturation:
   - Preload ch0 = 253 by steps from INIT=13 variant; up → 254, further ups → 254 with no changed pulse.
   - Down from 3 → 2.
5. Sel press → ch_sel = 1, threshold = ch1. Up → ch1 = 14, ch0 unchanged. Second sel → ch_sel = 0.
6. Both held together → no step. resetn pulsed during a REPEAT-state hold → all outputs at reset values; the held button produces no step until it is released and pressed again.
